// File: rtl/display_8x8_capture.sv
// -----------------------------------------------------------------------------
// display_8x8_capture
//
// Receive-side monitor for the 8x8 RGB LED display driver. It oversamples the
// driver's shift-register pin bundle in the system clock domain and rebuilds
// the red/green/blue frame being scanned out. It only observes the pins and
// never drives the display.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   sr_reset_n          monitored shift-register clear (active low)
//   oe_n                monitored output enable (synchronized, not used by capture)
//   sh_cp, st_cp, ds    monitored shift clock, latch clock, serial data
//   col_select[7:0]     monitored one-hot active column (bit k = column k)
//   image_red/green/blue[0:7][7:0]  captured frame; [0] = left column, MSB = top row
//   col_strobe, col_index           one-cycle pulse + index of the committed column
//   frame_done, frame_count         complete in-order frame pulse / wrapping count
//   err_bitcount, err_onehot, err_sequence  sticky protocol error flags
//
// Build option
//   CAPTURE_DBL_BUF_EN  commits go to a shadow buffer that is copied to the
//                       image outputs atomically when frame_done pulses.
//                       Undefined (default): the image outputs are written live,
//                       one cycle after each col_strobe.
// -----------------------------------------------------------------------------
module display_8x8_capture #(
  parameter int BITS_PER_COL = 24,
  parameter int SYNC_STAGES  = 2,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sr_reset_n,
  input  logic                   oe_n,
  input  logic                   sh_cp,
  input  logic                   st_cp,
  input  logic                   ds,
  input  logic [7:0]             col_select,
  output logic [0:7][7:0]        image_red,
  output logic [0:7][7:0]        image_green,
  output logic [0:7][7:0]        image_blue,
  output logic                   col_strobe,
  output logic [2:0]             col_index,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   err_bitcount,
  output logic                   err_onehot,
  output logic                   err_sequence
);

  localparam int         N_PINS      = 13;
  localparam logic [4:0] BIT_CNT_MAX = 5'd31;
  localparam logic [4:0] BIT_CNT_REQ = 5'(BITS_PER_COL);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [N_PINS-1:0]                  pins_raw;
  logic [N_PINS-1:0]                  pins_sync;
  logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q;   // [0] is the newest stage
  logic                               sr_reset_n_s;
  logic                               sh_cp_s;
  logic                               st_cp_s;
  logic                               ds_s;
  logic [7:0]                         col_select_s;
  logic                               sh_cp_q;
  logic                               st_cp_q;
  logic                               sh_rise;
  logic                               st_rise;
  // oe_n only gates the LEDs; the captured data does not depend on it.
  logic                               unused_oe_n;

  assign pins_raw = {col_select, ds, st_cp, sh_cp, oe_n, sr_reset_n};

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      sh_cp_q <= 1'b0;
      st_cp_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pins_raw};
      sh_cp_q <= sh_cp_s;
      st_cp_q <= st_cp_s;
    end
  end

  assign pins_sync    = sync_q[SYNC_STAGES-1];
  assign sr_reset_n_s = pins_sync[0];
  assign unused_oe_n  = pins_sync[1];
  assign sh_cp_s      = pins_sync[2];
  assign st_cp_s      = pins_sync[3];
  assign ds_s         = pins_sync[4];
  assign col_select_s = pins_sync[12:5];

  assign sh_rise = sh_cp_s & ~sh_cp_q;
  assign st_rise = st_cp_s & ~st_cp_q;

  // ---------------------------------------------------------------------------
  // Shift register next state. A commit in the same cycle as a shift sees the
  // freshly shifted word, so the commit path reads shreg_nx, not shreg.
  // ---------------------------------------------------------------------------
  logic [BITS_PER_COL-1:0] shreg;
  logic [BITS_PER_COL-1:0] shreg_nx;
  logic [4:0]              bit_cnt;
  logic [4:0]              bit_cnt_nx;
  logic                    sel_onehot;
  logic [2:0]              sel_idx;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    if (!sr_reset_n_s) begin
      shreg_nx   = '0;
      bit_cnt_nx = '0;
    end else if (sh_rise) begin
      shreg_nx = {shreg[BITS_PER_COL-2:0], ds_s};
      if (bit_cnt != BIT_CNT_MAX) begin
        bit_cnt_nx = bit_cnt + 5'd1;
      end
    end
  end

  always_comb begin
    sel_onehot = (col_select_s != 8'd0) && ((col_select_s & (col_select_s - 8'd1)) == 8'd0);
    sel_idx    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (col_select_s[k]) begin
        sel_idx = 3'(k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit handling and frame tracking
  // ---------------------------------------------------------------------------
  state_t     state;
  logic [2:0] expected;
  logic       bit_bad;
  logic       frame_fire;

  assign bit_bad    = (bit_cnt_nx != BIT_CNT_REQ);
  // Column 7 arriving in order closes a frame.
  assign frame_fire = st_rise && sel_onehot && !bit_bad && (state == COLLECT) &&
                      (sel_idx == expected) && (sel_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      state        <= HUNT;
      expected     <= 3'd0;
      col_strobe   <= 1'b0;
      col_index    <= 3'd0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      err_bitcount <= 1'b0;
      err_onehot   <= 1'b0;
      err_sequence <= 1'b0;
    end else begin
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt_nx;
      col_strobe <= 1'b0;
      frame_done <= 1'b0;

      if (st_rise) begin
        bit_cnt <= '0;
        if (!sel_onehot) begin
          // No target column: nothing is written and the frame is abandoned.
          err_onehot <= 1'b1;
          state      <= HUNT;
        end else begin
          col_strobe <= 1'b1;
          col_index  <= sel_idx;
          if (bit_bad) begin
            // The column is still written, but the frame cannot be trusted.
            err_bitcount <= 1'b1;
            state        <= HUNT;
          end else begin
            unique case (state)
              HUNT: begin
                if (sel_idx == 3'd0) begin
                  state    <= COLLECT;
                  expected <= 3'd1;
                end
              end
              COLLECT: begin
                if (sel_idx == expected) begin
                  if (frame_fire) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + FRAME_CNT_W'(1);
                    expected    <= 3'd0;
                  end else begin
                    expected <= expected + 3'd1;
                  end
                end else begin
                  err_sequence <= 1'b1;
                  if (sel_idx == 3'd0) begin
                    expected <= 3'd1;
                  end else begin
                    state <= HUNT;
                  end
                end
              end
              default: state <= HUNT;
            endcase
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Image storage
  // ---------------------------------------------------------------------------
`ifdef CAPTURE_DBL_BUF_EN
  logic [0:7][BITS_PER_COL-1:0] shadow;

  // NOTE: the shadow buffer has no reset; a column only reaches the outputs
  // after all eight have been rewritten in order since the last reset.
  always_ff @(posedge clk) begin
    if (st_rise && sel_onehot) begin
      shadow[sel_idx] <= shreg_nx;
    end
  end

  // Column 7 is still in flight to the shadow, so merge it in directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      image_red   <= '0;
      image_green <= '0;
      image_blue  <= '0;
    end else if (frame_fire) begin
      for (int c = 0; c < 8; c++) begin
        if (3'(c) == sel_idx) begin
          image_red[c]   <= shreg_nx[23:16];
          image_green[c] <= shreg_nx[15:8];
          image_blue[c]  <= shreg_nx[7:0];
        end else begin
          image_red[c]   <= shadow[c][23:16];
          image_green[c] <= shadow[c][15:8];
          image_blue[c]  <= shadow[c][7:0];
        end
      end
    end
  end
`else
  logic [BITS_PER_COL-1:0] commit_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_data <= '0;
    end else if (st_rise) begin
      commit_data <= shreg_nx;
    end
  end

  // Live update, one cycle behind the col_strobe that announced the column.
  always_ff @(posedge clk) begin
    if (reset) begin
      image_red   <= '0;
      image_green <= '0;
      image_blue  <= '0;
    end else if (col_strobe) begin
      image_red[col_index]   <= commit_data[23:16];
      image_green[col_index] <= commit_data[15:8];
      image_blue[col_index]  <= commit_data[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_display_8x8_capture.sv
// -----------------------------------------------------------------------------
// Bench for display_8x8_capture. Stimulus tasks drive the driver pin waveform
// and feed a behavioural model that tracks the panel contents, frame progress
// and error flags; every column strobe the model predicts is queued and a
// monitor compares it when the DUT raises col_strobe.
// -----------------------------------------------------------------------------
module tb_display_8x8_capture;

  logic            clk = 1'b0;
  logic            reset;
  logic            sr_reset_n;
  logic            oe_n;
  logic            sh_cp;
  logic            st_cp;
  logic            ds;
  logic [7:0]      col_select;
  logic [0:7][7:0] image_red;
  logic [0:7][7:0] image_green;
  logic [0:7][7:0] image_blue;
  logic            col_strobe;
  logic [2:0]      col_index;
  logic            frame_done;
  logic [15:0]     frame_count;
  logic            err_bitcount;
  logic            err_onehot;
  logic            err_sequence;

  always #5 clk = ~clk;

  display_8x8_capture #(
    .BITS_PER_COL(24),
    .SYNC_STAGES (2),
    .FRAME_CNT_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sr_reset_n  (sr_reset_n),
    .oe_n        (oe_n),
    .sh_cp       (sh_cp),
    .st_cp       (st_cp),
    .ds          (ds),
    .col_select  (col_select),
    .image_red   (image_red),
    .image_green (image_green),
    .image_blue  (image_blue),
    .col_strobe  (col_strobe),
    .col_index   (col_index),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .err_bitcount(err_bitcount),
    .err_onehot  (err_onehot),
    .err_sequence(err_sequence)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0]      idx;
    logic            fd;
    logic [15:0]     fcnt;
    logic [0:7][7:0] r;
    logic [0:7][7:0] g;
    logic [0:7][7:0] b;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [23:0]      m_shreg;
  int               m_cnt;
  logic [0:7][7:0]  m_red, m_green, m_blue;
  logic [0:7][23:0] m_shadow;
  bit               m_hunting;
  int               m_next;
  int               m_fcnt;
  bit               m_err_bc, m_err_oh, m_err_seq;

  task automatic model_reset();
    m_shreg   = '0;
    m_cnt     = 0;
    m_red     = '0;
    m_green   = '0;
    m_blue    = '0;
    m_shadow  = '0;
    m_hunting = 1'b1;
    m_next    = 0;
    m_fcnt    = 0;
    m_err_bc  = 1'b0;
    m_err_oh  = 1'b0;
    m_err_seq = 1'b0;
  endtask

  task automatic model_shift(input logic b);
    m_shreg = {m_shreg[22:0], b};
    if (m_cnt < 31) m_cnt++;
  endtask

  task automatic model_commit(input logic [7:0] sel);
    exp_t e;
    int   idx;
    bit   bad;
    idx = -1;
    if ($countones(sel) == 1) begin
      for (int k = 0; k < 8; k++) if (sel[k]) idx = k;
    end
    bad   = (m_cnt != 24);
    m_cnt = 0;
    if (idx < 0) begin
      m_err_oh  = 1'b1;
      m_hunting = 1'b1;
      return;
    end
    e.idx = 3'(idx);
    e.fd  = 1'b0;
    e.r   = m_red;
    e.g   = m_green;
    e.b   = m_blue;
    m_shadow[idx] = m_shreg;
    if (bad) begin
      m_err_bc  = 1'b1;
      m_hunting = 1'b1;
    end else if (m_hunting) begin
      if (idx == 0) begin
        m_hunting = 1'b0;
        m_next    = 1;
      end
    end else if (idx == m_next) begin
      if (idx == 7) begin
        e.fd   = 1'b1;
        m_fcnt = (m_fcnt + 1) % 65536;
        m_next = 0;
      end else begin
        m_next = m_next + 1;
      end
    end else begin
      m_err_seq = 1'b1;
      if (idx == 0) m_next = 1;
      else m_hunting = 1'b1;
    end
    e.fcnt = 16'(m_fcnt);
`ifdef CAPTURE_DBL_BUF_EN
    if (e.fd) begin
      for (int c = 0; c < 8; c++) begin
        m_red[c]   = m_shadow[c][23:16];
        m_green[c] = m_shadow[c][15:8];
        m_blue[c]  = m_shadow[c][7:0];
      end
    end
    e.r = m_red;
    e.g = m_green;
    e.b = m_blue;
`else
    m_red[idx]   = m_shreg[23:16];
    m_green[idx] = m_shreg[15:8];
    m_blue[idx]  = m_shreg[7:0];
`endif
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every strobe the DUT presents against the queue.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (frame_done) check("frame_done_has_strobe", col_strobe, 1'b1);
    if (col_strobe) begin
      check("strobe_was_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("col_index", col_index, mon_e.idx);
        check("frame_done", frame_done, mon_e.fd);
        check("frame_count", frame_count, mon_e.fcnt);
        check("image_red_at_strobe", image_red, mon_e.r);
        check("image_green_at_strobe", image_green, mon_e.g);
        check("image_blue_at_strobe", image_blue, mon_e.b);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_red"}, image_red, m_red);
    check({tag, "_green"}, image_green, m_green);
    check({tag, "_blue"}, image_blue, m_blue);
    check({tag, "_frame_count"}, frame_count, 16'(m_fcnt));
    check({tag, "_err_bitcount"}, err_bitcount, m_err_bc);
    check({tag, "_err_onehot"}, err_onehot, m_err_oh);
    check({tag, "_err_sequence"}, err_sequence, m_err_seq);
  endtask

  task automatic do_reset();
    check("queue_drained_before_reset", exp_q.size(), 0);
    reset = 1'b1;
    hold(1);
    reset = 1'b0;
    model_reset();
    check("rst_image_red", image_red, '0);
    check("rst_image_green", image_green, '0);
    check("rst_image_blue", image_blue, '0);
    check("rst_col_index", col_index, 3'd0);
    check("rst_col_strobe", col_strobe, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_count", frame_count, 16'd0);
    check("rst_errors", {err_bitcount, err_onehot, err_sequence}, 3'b000);
    hold(4);
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    hold(2);
    sh_cp = 1'b1;
    model_shift(b);
    hold(4);
    sh_cp = 1'b0;
    hold(2);
  endtask

  task automatic sr_pulse();
    sr_reset_n = 1'b0;
    m_shreg    = '0;
    m_cnt      = 0;
    hold(4);
    sr_reset_n = 1'b1;
    hold(4);
  endtask

  // Streams nbits MSB-first (zeros beyond the 24 data bits), then latches.
  // With merge set, the latch clock rises together with the last shift clock.
  task automatic drive_column(input logic [7:0] sel, input int nbits,
                              input logic [23:0] data, input bit merge);
    logic b;
    col_select = sel;
    for (int i = 0; i < nbits; i++) begin
      b = (nbits - 1 - i < 24) ? data[nbits-1-i] : 1'b0;
      if (merge && i == nbits - 1) begin
        ds = b;
        hold(2);
        sh_cp = 1'b1;
        st_cp = 1'b1;
        model_shift(b);
        model_commit(sel);
        hold(4);
        sh_cp = 1'b0;
        st_cp = 1'b0;
        hold(4);
      end else begin
        shift_bit(b);
      end
    end
    if (!merge) begin
      st_cp = 1'b1;
      model_commit(sel);
      hold(4);
      st_cp = 1'b0;
      hold(4);
    end
    checkpoint("col");
  endtask

  task automatic random_frame();
    for (int c = 0; c < 8; c++) drive_column(8'(1 << c), 24, 24'($urandom), 1'b0);
  endtask

  logic [7:0] rsel;
  int         rcol;
  int         rbits;

  initial begin
    reset      = 1'b1;
    sr_reset_n = 1'b1;
    oe_n       = 1'b0;
    sh_cp      = 1'b0;
    st_cp      = 1'b0;
    ds         = 1'b0;
    col_select = 8'h00;
    model_reset();
    hold(3);
    do_reset();

    // Clean frame
    for (int c = 0; c < 8; c++)
      drive_column(8'(1 << c), 24, {8'h03, 8'h00, (c == 3) ? 8'hCC : 8'h00}, 1'b0);
    check("clean_frame_count", frame_count, 16'd1);
    check("clean_blue3", image_blue[3], 8'hCC);
    check("clean_red0", image_red[0], 8'h03);

    // Short column, then a clean frame
    do_reset();
    drive_column(8'h01, 23, 24'($urandom), 1'b0);
    check("short_err_bitcount", err_bitcount, 1'b1);
    random_frame();
    check("short_then_frame_count", frame_count, 16'd1);

    // Bad select leaves the image alone and produces no strobe
    do_reset();
    drive_column(8'h01, 24, 24'h123456, 1'b0);
    drive_column(8'h05, 24, 24'($urandom), 1'b0);
    check("badsel_err_onehot", err_onehot, 1'b1);

    // Sequence skip, then a clean frame
    do_reset();
    drive_column(8'h01, 24, 24'($urandom), 1'b0);
    drive_column(8'h02, 24, 24'($urandom), 1'b0);
    drive_column(8'h08, 24, 24'($urandom), 1'b0);
    check("skip_err_sequence", err_sequence, 1'b1);
    random_frame();
    check("skip_frame_count", frame_count, 16'd1);

    // Shift-register reset mid-column discards the partial bits
    do_reset();
    for (int i = 0; i < 10; i++) shift_bit(1'($urandom));
    sr_pulse();
    drive_column(8'h04, 24, 24'hFF00AA, 1'b0);
    check("srrst_red2", image_red[2], 8'hFF);
    check("srrst_green2", image_green[2], 8'h00);
    check("srrst_blue2", image_blue[2], 8'hAA);
    check("srrst_err_bitcount", err_bitcount, 1'b0);

    // Reset mid-frame, then a full frame
    do_reset();
    for (int c = 0; c < 5; c++) drive_column(8'(1 << c), 24, 24'($urandom), 1'b0);
    do_reset();
    random_frame();

    // Shift and latch rising in the same cycle
    do_reset();
    for (int c = 0; c < 8; c++) drive_column(8'(1 << c), 24, 24'($urandom), c[0]);
    check("merge_frame_count", frame_count, 16'd1);
    check("merge_err_bitcount", err_bitcount, 1'b0);

    // Randomized traffic with occasional protocol faults
    do_reset();
    rcol = 0;
    for (int n = 0; n < 40; n++) begin
      rsel  = 8'(1 << rcol);
      rbits = 24;
      case ($urandom_range(0, 19))
        0: rsel = 8'(1 << $urandom_range(0, 7));
        1: begin
          rsel = 8'($urandom);
          if ($countones(rsel) == 1) rsel = 8'h00;
        end
        2: rbits = $urandom_range(20, 27);
        default: ;
      endcase
      drive_column(rsel, rbits, 24'($urandom), ($urandom_range(0, 4) == 0));
      rcol = (rcol + 1) % 8;
    end

    hold(10);
    check("all_strobes_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
